mux_n_pipe: RTL and testbench



---
 rtl/mux_n_pipe.sv | 164 ++++++++++++++++
 tb/tb_mux_n_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// N-input registered selector with a one-entry skid buffer.
// Full-throughput valid/ready, flush, and saturating bad-select count.
module mux_n_pipe #(
  parameter int DATA_W = 16,
  parameter int N_IN = 3,
  parameter int ERR_CNT_W = 8,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sel_err,
  output logic [ERR_CNT_W-1:0]   err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic              accept;
  logic              emit;
  logic              ready_q;
  logic [DATA_W-1:0] sel_data;
  logic              sel_err;
  logic [DATA_W-1:0] out_q;
  logic              out_err_q;
  logic [DATA_W-1:0] skid_q;
  logic              skid_err_q;
  logic              load_new;
  logic              load_skid;
  logic              load_move;

  assign accept = in_valid && ready_q && !flush;
  assign emit   = out_valid && out_ready;

  // Out-of-range selects resolve to zero with the error flag set.
  always_comb begin
    sel_data = '0;
    sel_err  = ({1'b0, in_sel} >= (SEL_W+1)'(N_IN));
    for (int k = 0; k < N_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) state_nx = ONE;
        end
        ONE: begin
          if (accept && !emit) begin
            state_nx = FULL;
          end else if (!accept && emit) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          if (emit) state_nx = ONE;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state != EMPTY);
    load_new  = 1'b0;
    load_skid = 1'b0;
    load_move = 1'b0;
    if (!flush) begin
      unique case (state)
        EMPTY: load_new = accept;
        ONE: begin
          load_new  = accept && emit;
          load_skid = accept && !emit;
        end
        FULL: load_move = emit;
        default: ;
      endcase
    end
  end

  // Registered so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_nx != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_err_q <= 1'b0;
    end else if (load_new) begin
      out_q     <= sel_data;
      out_err_q <= sel_err;
    end else if (load_move) begin
      out_q     <= skid_q;
      out_err_q <= skid_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q     <= '0;
      skid_err_q <= 1'b0;
    end else if (load_skid) begin
      skid_q     <= sel_data;
      skid_err_q <= sel_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (accept && sel_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign in_ready    = ready_q;
  assign out_data    = out_q;
  assign out_sel_err = out_err_q;

  a_full_blocks: assert property (
    @(posedge clk) disable iff (rst)
    (state == FULL) |-> !in_ready
  );

  a_hold: assert property (
    @(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush)
      |=> ($stable(out_data) && $stable(out_sel_err))
  );

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: directed table, corner sequences,
// and randomized multi-config run against a FIFO reference model.
module tb_mux_n_pipe;

  logic clk;
  logic rst;
  logic m_flush;

  logic         vv[4];
  logic         rv[4];
  logic [3:0]   sv[4];
  logic [127:0] dv[4];

  logic [15:0] m_od;
  logic        m_ov, m_ir, m_oe;
  logic [7:0]  m_ec;
  logic [7:0]  a_od;
  logic        a_ov, a_ir, a_oe;
  logic [7:0]  a_ec;
  logic [31:0] b_od;
  logic        b_ov, b_ir, b_oe;
  logic [7:0]  b_ec;
  logic [7:0]  c_od;
  logic        c_ov, c_ir, c_oe;
  logic [7:0]  c_ec;

  logic [1:0]  s_sel;
  logic        s_v, s_r, s_ir, s_ov, s_oe;
  logic [15:0] s_od;
  logic [1:0]  s_ec;

  mux_n_pipe #(.DATA_W(16), .N_IN(3), .ERR_CNT_W(8)) u_main (
    .clk(clk), .rst(rst), .in_data(dv[0][47:0]),
    .in_sel(sv[0][1:0]), .in_valid(vv[0]), .in_ready(m_ir),
    .flush(m_flush), .out_data(m_od), .out_valid(m_ov),
    .out_ready(rv[0]), .out_sel_err(m_oe), .err_count(m_ec)
  );

  mux_n_pipe #(.DATA_W(8), .N_IN(2), .ERR_CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_data(dv[1][15:0]),
    .in_sel(sv[1][0:0]), .in_valid(vv[1]), .in_ready(a_ir),
    .flush(1'b0), .out_data(a_od), .out_valid(a_ov),
    .out_ready(rv[1]), .out_sel_err(a_oe), .err_count(a_ec)
  );

  mux_n_pipe #(.DATA_W(32), .N_IN(4), .ERR_CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_data(dv[2][127:0]),
    .in_sel(sv[2][1:0]), .in_valid(vv[2]), .in_ready(b_ir),
    .flush(1'b0), .out_data(b_od), .out_valid(b_ov),
    .out_ready(rv[2]), .out_sel_err(b_oe), .err_count(b_ec)
  );

  mux_n_pipe #(.DATA_W(8), .N_IN(16), .ERR_CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .in_data(dv[3][127:0]),
    .in_sel(sv[3][3:0]), .in_valid(vv[3]), .in_ready(c_ir),
    .flush(1'b0), .out_data(c_od), .out_valid(c_ov),
    .out_ready(rv[3]), .out_sel_err(c_oe), .err_count(c_ec)
  );

  mux_n_pipe #(.DATA_W(16), .N_IN(3), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_data(48'h3333_2222_1111),
    .in_sel(s_sel), .in_valid(s_v), .in_ready(s_ir),
    .flush(1'b0), .out_data(s_od), .out_valid(s_ov),
    .out_ready(s_r), .out_sel_err(s_oe), .err_count(s_ec)
  );

  logic [31:0] od_o[4];
  logic        ov_o[4], ir_o[4], oe_o[4];
  logic [7:0]  ec_o[4];

  always_comb begin
    od_o[0] = 32'(m_od); ov_o[0] = m_ov; ir_o[0] = m_ir;
    oe_o[0] = m_oe; ec_o[0] = m_ec;
    od_o[1] = 32'(a_od); ov_o[1] = a_ov; ir_o[1] = a_ir;
    oe_o[1] = a_oe; ec_o[1] = a_ec;
    od_o[2] = b_od; ov_o[2] = b_ov; ir_o[2] = b_ir;
    oe_o[2] = b_oe; ec_o[2] = b_ec;
    od_o[3] = 32'(c_od); ov_o[3] = c_ov; ir_o[3] = c_ir;
    oe_o[3] = c_oe; ec_o[3] = c_ec;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        v, r, f;
    logic        ov;
    logic [15:0] od;
    logic        oe, ir;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl[18];

  int          niv[4];
  int          swv[4];
  int          dwv[4];
  int unsigned w[4][16];
  int unsigned mem[4][256];
  logic        merr[4][256];
  int          hd[4], tl[4], ecm[4], selv[4];

  initial begin
    total = 0;
    passed = 0;
    niv = '{3, 2, 4, 16};
    swv = '{2, 1, 2, 4};
    dwv = '{16, 8, 32, 8};
    rst = 1'b1;
    m_flush = 1'b0;
    s_sel = 2'd0; s_v = 1'b0; s_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vv[i] = 1'b0; rv[i] = 1'b1; sv[i] = '0; dv[i] = '0;
    end
    dv[0] = 128'h3333_2222_1111;

    //      sel  v  r  f  ov  od    oe  ir  ec
    tbl[0]  = '{2'd0,1,1,0, 1,16'h1111,0,1,8'd0};
    tbl[1]  = '{2'd1,1,1,0, 1,16'h2222,0,1,8'd0};
    tbl[2]  = '{2'd2,1,1,0, 1,16'h3333,0,1,8'd0};
    tbl[3]  = '{2'd0,1,1,0, 1,16'h1111,0,1,8'd0};
    tbl[4]  = '{2'd0,0,1,0, 0,16'h0000,0,1,8'd0};
    tbl[5]  = '{2'd1,1,0,0, 1,16'h2222,0,1,8'd0};
    tbl[6]  = '{2'd2,1,0,0, 1,16'h2222,0,0,8'd0};
    tbl[7]  = '{2'd0,1,0,0, 1,16'h2222,0,0,8'd0};
    tbl[8]  = '{2'd0,0,1,0, 1,16'h3333,0,1,8'd0};
    tbl[9]  = '{2'd0,0,1,0, 0,16'h0000,0,1,8'd0};
    tbl[10] = '{2'd3,1,1,0, 1,16'h0000,1,1,8'd1};
    tbl[11] = '{2'd1,1,1,0, 1,16'h2222,0,1,8'd1};
    tbl[12] = '{2'd3,1,0,0, 1,16'h2222,0,0,8'd2};
    tbl[13] = '{2'd0,0,0,0, 1,16'h2222,0,0,8'd2};
    tbl[14] = '{2'd3,1,1,1, 0,16'h0000,0,1,8'd2};
    tbl[15] = '{2'd0,1,1,0, 1,16'h1111,0,1,8'd2};
    tbl[16] = '{2'd3,1,0,1, 0,16'h0000,0,1,8'd2};
    tbl[17] = '{2'd0,0,0,0, 0,16'h0000,0,1,8'd2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", m_ov, 0);
    chk("reset out_data", m_od, 0);
    chk("reset sel_err", m_oe, 0);
    chk("reset err_count", m_ec, 0);
    chk("reset in_ready", m_ir, 1);

    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      sv[0] = 4'(tbl[t].sel);
      vv[0] = tbl[t].v;
      rv[0] = tbl[t].r;
      m_flush = tbl[t].f;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", t), m_ov, tbl[t].ov);
      chk($sformatf("row%0d in_ready", t), m_ir, tbl[t].ir);
      chk($sformatf("row%0d err_count", t), m_ec, tbl[t].ec);
      if (tbl[t].ov) begin
        chk($sformatf("row%0d out_data", t), m_od, tbl[t].od);
        chk($sformatf("row%0d sel_err", t), m_oe, tbl[t].oe);
      end
    end

    // Reset while the skid buffer is occupied.
    @(negedge clk);
    m_flush = 1'b0; sv[0] = 4'd1; vv[0] = 1'b1; rv[0] = 1'b0;
    @(negedge clk);
    sv[0] = 4'd3;
    @(posedge clk);
    #1;
    chk("pre-rst in_ready", m_ir, 0);
    chk("pre-rst err_count", m_ec, 3);
    @(negedge clk);
    rst = 1'b1; sv[0] = 4'd0;
    @(posedge clk);
    #1;
    chk("mid-rst out_valid", m_ov, 0);
    chk("mid-rst out_data", m_od, 0);
    chk("mid-rst sel_err", m_oe, 0);
    chk("mid-rst err_count", m_ec, 0);
    chk("mid-rst in_ready", m_ir, 1);
    @(negedge clk);
    rst = 1'b0; sv[0] = 4'd2; vv[0] = 1'b1; rv[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst out_valid", m_ov, 1);
    chk("post-rst out_data", m_od, 16'h3333);
    @(negedge clk);
    vv[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst drained", m_ov, 0);

    // Saturation with a 2-bit counter.
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      s_sel = 2'd3; s_v = 1'b1; s_r = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d err_count", t), s_ec, (t < 3) ? t + 1 : 3);
      chk($sformatf("sat%0d out_data", t), s_od, 0);
      chk($sformatf("sat%0d sel_err", t), s_oe, 1);
    end
    @(negedge clk);
    s_v = 1'b0;

    // Randomized run on all configurations.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vv[i] = 1'b0; hd[i] = 0; tl[i] = 0; ecm[i] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 3006; cyc++) begin
      automatic bit drain = (cyc >= 3000);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        automatic int unsigned mask;
        automatic logic [127:0] pk = '0;
        mask = (dwv[i] == 32) ? 32'hFFFF_FFFF
                              : ((32'd1 << dwv[i]) - 1);
        vv[i] = drain ? 1'b0 : ($urandom_range(3) != 0);
        rv[i] = drain ? 1'b1 : ($urandom_range(2) != 0);
        selv[i] = int'($urandom_range((1 << swv[i]) - 1));
        sv[i] = 4'(selv[i]);
        for (int k = 0; k < 16; k++) w[i][k] = $urandom & mask;
        for (int k = niv[i] - 1; k >= 0; k--) begin
          pk = (pk << dwv[i]) | 128'(w[i][k]);
        end
        dv[i] = pk;
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        automatic int occ = tl[i] - hd[i];
        chk($sformatf("rnd%0d out_valid", i), ov_o[i], occ > 0);
        chk($sformatf("rnd%0d in_ready", i), ir_o[i], occ < 2);
        chk($sformatf("rnd%0d err_count", i), ec_o[i], ecm[i]);
        if (ov_o[i] && rv[i] && occ > 0) begin
          chk($sformatf("rnd%0d data", i), od_o[i], mem[i][hd[i] % 256]);
          chk($sformatf("rnd%0d sel_err", i), oe_o[i], merr[i][hd[i] % 256]);
          hd[i]++;
        end
        if (vv[i] && ir_o[i]) begin
          automatic bit bad = (selv[i] >= niv[i]);
          mem[i][tl[i] % 256] = bad ? 0 : w[i][selv[i]];
          merr[i][tl[i] % 256] = bad;
          tl[i]++;
          if (bad && ecm[i] < 255) ecm[i]++;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rnd%0d leftover", i), tl[i] - hd[i], 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
